// File: rtl/mem_calib_supervisor.sv
// DDR bring-up supervisor: pulses the memory reset, waits for a stable mem_ok,
// retries on calibration timeout or loss of mem_ok, and latches a failure once retries run out.
module mem_calib_supervisor #(
  parameter int RESET_PULSE   = 64,
  parameter int CALIB_TIMEOUT = 16777216,
  parameter int HOLDOFF       = 1024,
  parameter int MAX_RETRIES   = 3
) (
  input  logic       clock,
  input  logic       aresetn,
  input  logic       enable,
  input  logic       mem_ok,
  input  logic       clear_fail,
  output logic       mem_sys_reset,
  output logic       mem_ready,
  output logic       mem_fail,
  output logic [3:0] retry_count,
  output logic [2:0] state
);

  localparam int PULSE_W = (RESET_PULSE > 1) ? $clog2(RESET_PULSE) : 1;
  localparam int TMO_W   = (CALIB_TIMEOUT > 1) ? $clog2(CALIB_TIMEOUT) : 1;
  localparam int HOLD_W  = (HOLDOFF > 1) ? $clog2(HOLDOFF) : 1;

  localparam logic [PULSE_W-1:0] PULSE_LAST = PULSE_W'(RESET_PULSE - 1);
  localparam logic [TMO_W-1:0]   TMO_LAST   = TMO_W'(CALIB_TIMEOUT - 1);
  localparam logic [HOLD_W-1:0]  HOLD_LAST  = HOLD_W'(HOLDOFF - 1);
  localparam logic [3:0]         RETRY_MAX  = 4'(MAX_RETRIES);

  typedef enum logic [2:0] {
    S_IDLE       = 3'd0,
    S_RESET      = 3'd1,
    S_WAIT_CALIB = 3'd2,
    S_STABLE     = 3'd3,
    S_READY      = 3'd4,
    S_FAIL       = 3'd5
  } state_t;

  state_t state_reg, state_next;

  (* ASYNC_REG = "TRUE" *) logic [1:0] sync_reg;
  logic mem_ok_s;

  logic [PULSE_W-1:0] pulse_reg, pulse_next;
  logic [TMO_W-1:0]   tmo_reg, tmo_next;
  logic [HOLD_W-1:0]  hold_reg, hold_next;
  logic [3:0]         retry_reg, retry_next;

  logic mem_sys_reset_reg, mem_sys_reset_next;
  logic mem_ready_reg, mem_ready_next;
  logic mem_fail_reg, mem_fail_next;

  logic tmo_last, hold_last, fault;

  // mem_ok comes from another domain; only the second stage is ever looked at
  always_ff @(posedge clock or negedge aresetn) begin
    if (!aresetn) begin
      sync_reg <= '0;
    end else begin
      sync_reg <= {sync_reg[0], mem_ok};
    end
  end

  assign mem_ok_s  = sync_reg[1];
  assign tmo_last  = (tmo_reg == TMO_LAST);
  assign hold_last = (hold_reg == HOLD_LAST);

  always_comb begin
    state_next = state_reg;
    retry_next = retry_reg;
    fault      = 1'b0;

    case (state_reg)
      S_IDLE: begin
        if (enable) begin
          retry_next = '0;
          state_next = S_RESET;
        end
      end
      S_RESET: begin
        if (pulse_reg == PULSE_LAST) state_next = S_WAIT_CALIB;
      end
      S_WAIT_CALIB: begin
        if (tmo_last)      fault      = 1'b1;
        else if (mem_ok_s) state_next = S_STABLE;
      end
      S_STABLE: begin
        // reaching READY on the last timeout cycle still counts as success
        if (mem_ok_s && hold_last) state_next = S_READY;
        else if (tmo_last)         fault      = 1'b1;
        else if (!mem_ok_s)        state_next = S_WAIT_CALIB;
      end
      S_READY: begin
        if (!mem_ok_s) fault = 1'b1;
      end
      S_FAIL: begin
        if (clear_fail) state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase

    if (fault) begin
      if (retry_reg < RETRY_MAX) begin
        retry_next = retry_reg + 4'd1;
        state_next = S_RESET;
      end else begin
        state_next = S_FAIL;
      end
    end

    // dropping enable aborts everything except a latched failure
    if (!enable && state_reg != S_FAIL) begin
      state_next = S_IDLE;
      retry_next = retry_reg;
    end
  end

  always_comb begin
    pulse_next = '0;
    hold_next  = '0;
    tmo_next   = tmo_reg;

    if (state_reg == S_RESET && state_next == S_RESET) pulse_next = pulse_reg + 1'b1;
    if (state_reg == S_STABLE && state_next == S_STABLE) hold_next = hold_reg + 1'b1;

    if (state_next == S_RESET) begin
      tmo_next = '0;
    end else if (state_reg == S_WAIT_CALIB || state_reg == S_STABLE) begin
      tmo_next = tmo_reg + 1'b1;
    end
  end

  // outputs decode the state being entered so they line up with state_reg
  always_comb begin
    mem_sys_reset_next = (state_next == S_IDLE) || (state_next == S_RESET) ||
                         (state_next == S_FAIL);
    mem_ready_next     = (state_next == S_READY);
    mem_fail_next      = (state_next == S_FAIL);
  end

  always_ff @(posedge clock or negedge aresetn) begin
    if (!aresetn) begin
      state_reg         <= S_IDLE;
      pulse_reg         <= '0;
      tmo_reg           <= '0;
      hold_reg          <= '0;
      retry_reg         <= '0;
      mem_sys_reset_reg <= 1'b1;
      mem_ready_reg     <= 1'b0;
      mem_fail_reg      <= 1'b0;
    end else begin
      state_reg         <= state_next;
      pulse_reg         <= pulse_next;
      tmo_reg           <= tmo_next;
      hold_reg          <= hold_next;
      retry_reg         <= retry_next;
      mem_sys_reset_reg <= mem_sys_reset_next;
      mem_ready_reg     <= mem_ready_next;
      mem_fail_reg      <= mem_fail_next;
    end
  end

  assign mem_sys_reset = mem_sys_reset_reg;
  assign mem_ready     = mem_ready_reg;
  assign mem_fail      = mem_fail_reg;
  assign retry_count   = retry_reg;
  assign state         = state_reg;

endmodule

// File: doc/mem_calib_supervisor.md
# mem_calib_supervisor

Supervises DDR memory bring-up on top of the memory reset control. It drives that block's `sys_reset` input, waits for the combined `mem_ok` indication, and requires `mem_ok` to stay stable before declaring memory ready. On calibration timeout or loss of `mem_ok` it re-issues the reset, up to a bounded retry count, then latches a failure for firmware and status LEDs. It sits in the `clock` (200 MHz board clock) domain between board-level enable/status logic and the DDR reset path.

## Interface
Parameters:
- `RESET_PULSE`, 64: cycles `mem_sys_reset` is held high per attempt; ≥1.
- `CALIB_TIMEOUT`, 16777216: cycles allowed from end of reset pulse to ready; ≥ `HOLDOFF`+1.
- `HOLDOFF`, 1024: consecutive cycles of synchronized `mem_ok` required before ready; ≥1.
- `MAX_RETRIES`, 3: re-attempts after the first; 0..15.

Ports:
- `clock`, in, 1: single clock; all logic on rising edge.
- `aresetn`, in, 1: asynchronous, active-low reset.
- `enable`, in, 1: level; high requests memory bring-up and hold-up.
- `mem_ok`, in, 1: from reset control; asynchronous to `clock`.
- `clear_fail`, in, 1: one-cycle pulse; leaves FAIL.
- `mem_sys_reset`, out, 1: active-high reset to the memory reset control.
- `mem_ready`, out, 1: memory usable.
- `mem_fail`, out, 1: retries exhausted.
- `retry_count`, out, 4: retries consumed in the current sequence.
- `state`, out, 3: FSM state code.

## Operation
- `mem_ok` passes through a 2-flop `ASYNC_REG` synchronizer, giving `mem_ok_s`. Only `mem_ok_s` is used.
- State codes:
  - IDLE=0
  - RESET=1
  - WAIT_CALIB=2
  - STABLE=3
  - READY=4
  - FAIL=5
- IDLE: `mem_sys_reset`=1. If `enable`=1, clear `retry_count` and go to RESET.
- RESET: `mem_sys_reset`=1 for exactly `RESET_PULSE` cycles, then go to WAIT_CALIB. Entering RESET clears the timeout counter.
- WAIT_CALIB: `mem_sys_reset`=0; the timeout counter increments every cycle. If `mem_ok_s`=1, go to STABLE with the holdoff counter cleared.
- STABLE: the timeout counter keeps running and the holdoff counter increments.
  - `mem_ok_s`=0: return to WAIT_CALIB.
  - Holdoff counter reaches `HOLDOFF`-1 with `mem_ok_s`=1: go to READY.
- Timeout: in WAIT_CALIB or STABLE, when the timeout counter equals `CALIB_TIMEOUT`-1 and READY is not being entered that cycle, declare a fault.
  - READY entry wins over a timeout in the same cycle.
- READY: `mem_ready`=1. `mem_ok_s`=0 declares a fault.
- Fault: if `retry_count` < `MAX_RETRIES`, increment `retry_count` and go to RESET. Otherwise go to FAIL.
- FAIL: `mem_fail`=1, `mem_sys_reset`=1. `clear_fail`=1 goes to IDLE. `retry_count` holds its value until IDLE is left.
- `enable`=0 in any state except FAIL: go to IDLE next cycle. This takes priority over every other transition. `retry_count` is not cleared until the next start.
- `clear_fail` outside FAIL is ignored.
- `retry_count` saturates at `MAX_RETRIES` and never wraps.
- Counter widths: `$clog2` of the parameter, minimum 1.

## Timing
- Reset values:
  - `state`=IDLE
  - `mem_sys_reset`=1
  - `mem_ready`=0
  - `mem_fail`=0
  - `retry_count`=0
  - both counters = 0
  - synchronizer = 0
- All outputs are registered. Each output reflects the state entered on the same edge: outputs decode next-state, so there is no extra cycle of lag.
- `mem_ok` to `mem_ok_s` latency: 2 cycles.
- `enable` rise in IDLE to `mem_sys_reset` high: already high. The first WAIT_CALIB cycle (`mem_sys_reset`=0) is `RESET_PULSE`+1 edges after the `enable` sample.
- Minimum time from `mem_ok` rising to `mem_ready`=1: 2 (sync) + 1 (enter STABLE) + `HOLDOFF` cycles.
- `mem_ok` dropping while READY: `mem_ready` falls and `mem_sys_reset` rises 3 cycles after the `mem_ok` edge (2 sync + 1).
- `aresetn` assertion forces reset values asynchronously. Deassertion is used as-is; the board synchronizes it externally.
- Reset mid-sequence aborts the attempt and returns to IDLE with `mem_sys_reset`=1 immediately.

## Test plan
All scenarios use `RESET_PULSE`=4, `CALIB_TIMEOUT`=32, `HOLDOFF`=8, `MAX_RETRIES`=2.
- Normal bring-up: `enable`=1, and `mem_ok` rises 10 cycles into WAIT_CALIB and stays high. Required: `mem_sys_reset` high for exactly 4 cycles; `mem_ready`=1 exactly 2+1+8 cycles after the `mem_ok` edge; `retry_count`=0.
- Glitch during holdoff: `mem_ok` high 5 cycles, low 1, then high. Required: state returns 3 to 2 to 3, the holdoff restarts, and the timeout counter is not cleared.
- Timeout and retries: `mem_ok` held 0. Required: three reset pulses of 4 cycles each, `retry_count` steps 0 to 1 to 2, then `state`=5, `mem_fail`=1, `mem_sys_reset`=1.
- Loss in READY: reach READY, then drop `mem_ok`. Required: `mem_ready`=0 after 3 cycles, `retry_count`=1, and a new 4-cycle reset pulse.
- Control: in FAIL, `clear_fail` pulse leads to IDLE with `retry_count` held; raising `enable` clears it to 0. `enable`=0 mid-WAIT_CALIB leads to IDLE the next cycle. `aresetn` low mid-RESET restores all reset values asynchronously.
- Boundary: `mem_ok` rises so READY entry lands on timeout count 31. Required: READY is entered and there is no retry.
